lin_header_tx: RTL and testbench
================================

// Module: lin_header_tx
// PURPOSE
//  LIN master header transmitter: on request, serialises one complete LIN header
//  (break, break delimiter, sync 0x55, protected identifier) onto the bus TX line.
//  It is the sending end of the header that slave-side PID detection consumes.
//  Computes PID parity from a 6-bit frame ID. Each byte field is 10 bits:
//  bit0 start = 0, bits[8:1] data LSB first, bit9 stop = 1.
//  Sits in the APB LIN top between the register block (start, ID) and the bus PHY.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per LIN bit time (>= 2)
//  BREAK_BITS    13  break-field length in bit times, dominant (>= 13)
//  DELIM_BITS    1   break-delimiter length in bit times, recessive (>= 1)
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  reset     in   1  synchronous reset, active-low
//  start     in   1  header request; sampled only in IDLE
//  frame_id  in   6  frame identifier ID[5:0]; captured when start is accepted
//  tx        out  1  bus transmit line, 1 = recessive
//  busy      out  1  high from the cycle after accept until done
//  done      out  1  one-cycle pulse when the PID stop bit has completed
//  pid_out   out  8  protected ID being or last transmitted: {P1,P0,ID[5:0]}
// BEHAVIOUR
//  Reset (reset=0 at a clk edge): tx=1, busy=0, done=0, pid_out=0, state IDLE,
//   all counters 0. Applies mid-header: tx goes recessive at that edge; header aborted.
//  Parity: P0 = ID0^ID1^ID2^ID4; P1 = ~(ID1^ID3^ID4^ID5).
//  Accept: in IDLE with start=1 -> at that edge latch frame_id, load pid_out,
//   state BREAK, busy=1, tx=0, bit_cnt=0, clk_cnt=0. start=0 in IDLE: stay, tx=1.
//  start while busy is ignored, with no queueing. frame_id changes after accept are ignored.
//  Bit timing: clk_cnt counts 0..CLKS_PER_BIT-1. A bit period ends when clk_cnt wraps.
//   Each tx level is held for exactly CLKS_PER_BIT cycles.
//  FSM (tx value per bit; transition at end of last bit of field):
//   IDLE  tx=1
//   BREAK tx=0 for BREAK_BITS bits                      -> DELIM
//   DELIM tx=1 for DELIM_BITS bits                      -> SYNC
//   SYNC  tx=frame bit n of {1,8'h55,0} (n=0..9)        -> PID
//   PID   tx=frame bit n of {1,pid_out,0} (n=0..9)      -> IDLE
//  PID->IDLE edge: done=1 for one cycle, busy=0, tx=1. pid_out holds until next accept.
//  Latency: first tx=0 one cycle after accept. Done is asserted
//   (BREAK_BITS+DELIM_BITS+20)*CLKS_PER_BIT cycles after accept (544 with defaults).
//  start=1 in the cycle done is high is accepted, giving back-to-back headers with
//   no extra recessive idle beyond the PID stop bit.
//  Counters never overflow: clk_cnt width clog2(CLKS_PER_BIT),
//   bit_cnt width clog2(max(BREAK_BITS,10)+1). Both clear at each field change.
// TESTING
//  1 reset held 3 cycles, then released -> tx=1, busy=0, done=0, pid_out=0x00
//  2 start pulse, frame_id=0x16 -> pid_out=0xD6; tx low 208 cycles, high 16 cycles,
//    then 0x55 framed, then 0xD6 framed LSB first. done pulses at cycle 544.
//    A UART-style sampler at mid-bit recovers 0x55 and 0xD6 with valid stop bits.
//  3 parity table: ID 0x00->0x80, 0x3C->0x3C, 0x3D->0x7D, 0x16->0xD6, 0x3F->0xBF
//  4 start re-asserted at cycle 100 with frame_id=0x01 -> ignored; header and pid_out
//    unchanged. start held high through done -> second header begins the next cycle
//  5 reset asserted mid-SYNC (cycle 300) -> tx=1 and busy=0 at that edge, no done pulse.
//    A new start after release yields a full 544-cycle header
//  6 CLKS_PER_BIT=4, BREAK_BITS=15, DELIM_BITS=2 -> break 60 cycles, delimiter 8 cycles,
//    done at (15+2+20)*4=148 cycles after accept

Source files
------------

// File: rtl/lin_header_tx.sv
// LIN master header transmitter: break, break delimiter, sync 0x55 and the
// protected identifier, serialised onto tx with one shared bit timer.
module lin_header_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned BREAK_BITS   = 13,
  parameter int unsigned DELIM_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] frame_id,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] pid_out
);

  localparam int unsigned FIELD_BITS = 10;
  localparam int unsigned BIT_MAX_A  = (BREAK_BITS > FIELD_BITS) ? BREAK_BITS : FIELD_BITS;
  localparam int unsigned BIT_MAX    = (DELIM_BITS > BIT_MAX_A) ? DELIM_BITS : BIT_MAX_A;
  localparam int unsigned BCW        = $clog2(BIT_MAX + 1);
  localparam int unsigned CCW        = $clog2(CLKS_PER_BIT);

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BREAK = 3'd1;
  localparam logic [2:0] S_DELIM = 3'd2;
  localparam logic [2:0] S_SYNC  = 3'd3;
  localparam logic [2:0] S_PID   = 3'd4;

  logic [2:0]     state_q,   state_d;
  logic [CCW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           tx_q,      tx_d;
  logic           busy_q,    busy_d;
  logic           done_q,    done_d;
  logic [7:0]     pid_q,     pid_d;

  logic           bit_end_c;
  logic           field_end_c;
  logic [BCW-1:0] bit_nxt_c;

  // Protected identifier: ID with two parity bits on top
  function automatic logic [7:0] calc_pid(input logic [5:0] id);
    logic p0;
    logic p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  // Bit idx of a UART-style byte frame: start 0, data LSB first, stop 1
  function automatic logic frame_bit(input logic [7:0] data, input logic [BCW-1:0] idx);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0} >> idx;
    return frame[0];
  endfunction

  assign bit_end_c   = (clk_cnt_q == CCW'(CLKS_PER_BIT - 1));
  assign field_end_c = (bit_cnt_q == BCW'(FIELD_BITS - 1));
  assign bit_nxt_c   = bit_cnt_q + BCW'(1);

  // Next-state, bit timing and tx level for the following cycle
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pid_d     = pid_q;

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end_c ? '0 : clk_cnt_q + CCW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (start) begin
          pid_d   = calc_pid(frame_id);
          state_d = S_BREAK;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end
      S_BREAK: begin
        if (bit_end_c) begin
          if (bit_cnt_q == BCW'(BREAK_BITS - 1)) begin
            state_d   = S_DELIM;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_nxt_c;
          end
        end
      end
      S_DELIM: begin
        if (bit_end_c) begin
          if (bit_cnt_q == BCW'(DELIM_BITS - 1)) begin
            state_d   = S_SYNC;
            bit_cnt_d = '0;
            tx_d      = frame_bit(SYNC_BYTE, '0);
          end else begin
            bit_cnt_d = bit_nxt_c;
          end
        end
      end
      S_SYNC: begin
        if (bit_end_c) begin
          if (field_end_c) begin
            state_d   = S_PID;
            bit_cnt_d = '0;
            tx_d      = frame_bit(pid_q, '0);
          end else begin
            bit_cnt_d = bit_nxt_c;
            tx_d      = frame_bit(SYNC_BYTE, bit_nxt_c);
          end
        end
      end
      S_PID: begin
        if (bit_end_c) begin
          if (field_end_c) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_nxt_c;
            tx_d      = frame_bit(pid_q, bit_nxt_c);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any header in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pid_q     <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pid_q     <= pid_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pid_out = pid_q;

endmodule

// File: tb/tb_lin_header_tx.sv
// Bench for lin_header_tx: default instance plus a short-timing instance.
module tb_lin_header_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic [5:0] id0, id1;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;
  logic [7:0] pid0, pid1;

  int n_checks = 0;
  int n_pass   = 0;

  logic wave [0:1023];

  typedef struct {
    logic [5:0] id;
    logic [7:0] pid;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  lin_header_tx dut0 (
    .clk(clk), .reset(reset), .start(start0), .frame_id(id0),
    .tx(tx0), .busy(busy0), .done(done0), .pid_out(pid0)
  );

  lin_header_tx #(.CLKS_PER_BIT(4), .BREAK_BITS(15), .DELIM_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .frame_id(id1),
    .tx(tx1), .busy(busy1), .done(done1), .pid_out(pid1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic g_tx(input int sel);   return (sel != 0) ? tx1 : tx0;     endfunction
  function automatic logic g_busy(input int sel); return (sel != 0) ? busy1 : busy0; endfunction
  function automatic logic g_done(input int sel); return (sel != 0) ? done1 : done0; endfunction
  function automatic logic [7:0] g_pid(input int sel); return (sel != 0) ? pid1 : pid0; endfunction

  task automatic set_in(input int sel, input logic s, input logic [5:0] id);
    if (sel != 0) begin start1 = s; id1 = id; end
    else begin start0 = s; id0 = id; end
  endtask

  // Reference tx level at cycle i after the accepting edge
  function automatic logic exp_tx(input int i, input int cpb, input int brk, input int dlm,
                                  input logic [7:0] pid);
    int b;
    logic [9:0] f;
    b = i / cpb;
    if (b < brk) return 1'b0;
    if (b < brk + dlm) return 1'b1;
    b = b - brk - dlm;
    if (b < 10) f = {1'b1, 8'h55, 1'b0};
    else begin f = {1'b1, pid, 1'b0}; b = b - 10; end
    return f[b];
  endfunction

  // Mid-bit sampling of one 10-bit field from the recorded waveform
  function automatic logic [9:0] uart_field(input int base, input int cpb);
    logic [9:0] r;
    for (int k = 0; k < 10; k++) r[k] = wave[base + k * cpb + cpb / 2];
    return r;
  endfunction

  // One complete header: accept, cycle-by-cycle waveform, done pulse
  task automatic run_header(input int sel, input logic [5:0] id, input logic [7:0] exp_pid,
                            input int cpb, input int brk, input int dlm,
                            input int glitch, input logic hold);
    int n;
    int errs;
    int first_bad;
    n = (brk + dlm + 20) * cpb;
    errs = 0;
    first_bad = -1;
    set_in(sel, 1'b1, id);
    step();
    set_in(sel, hold, id ^ 6'h2A);
    check("pid_accept", 32'(g_pid(sel)), 32'(exp_pid));
    for (int i = 0; i < n; i++) begin
      if (i == glitch) set_in(sel, 1'b1, 6'h01);
      else if (i == glitch + 1) set_in(sel, hold, 6'h01);
      wave[i] = g_tx(sel);
      if (g_tx(sel) !== exp_tx(i, cpb, brk, dlm, exp_pid) || g_busy(sel) !== 1'b1 ||
          g_done(sel) !== 1'b0) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      step();
    end
    if (errs != 0) $display("  first waveform deviation at cycle %0d", first_bad);
    check("header_wave_errs", 32'(errs), 32'd0);
    check("uart_sync", 32'(uart_field((brk + dlm) * cpb, cpb)), 32'({1'b1, 8'h55, 1'b0}));
    check("uart_pid", 32'(uart_field((brk + dlm + 10) * cpb, cpb)), 32'({1'b1, exp_pid, 1'b0}));
    check("done_at_end", 32'({g_done(sel), g_busy(sel), g_tx(sel)}), 32'b101);
    check("pid_hold", 32'(g_pid(sel)), 32'(exp_pid));
    if (!hold) begin
      step();
      check("after_done", 32'({g_done(sel), g_busy(sel), g_tx(sel)}), 32'b001);
    end
  endtask

  initial begin
    logic done_seen;

    vecs[0] = '{id: 6'h16, pid: 8'hD6};
    vecs[1] = '{id: 6'h00, pid: 8'h80};
    vecs[2] = '{id: 6'h3C, pid: 8'h3C};
    vecs[3] = '{id: 6'h3D, pid: 8'h7D};
    vecs[4] = '{id: 6'h3F, pid: 8'hBF};

    reset = 1'b0;
    set_in(0, 1'b0, 6'h00);
    set_in(1, 1'b0, 6'h00);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_dut0", 32'({tx0, busy0, done0, pid0}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    check("rst_dut1", 32'({tx1, busy1, done1, pid1}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));

    for (int v = 0; v < 5; v++)
      run_header(0, vecs[v].id, vecs[v].pid, 16, 13, 1, -1, 1'b0);

    // Start ignored mid-header, then held through done for back-to-back
    run_header(0, 6'h16, 8'hD6, 16, 13, 1, 100, 1'b1);
    run_header(0, 6'h2A, 8'h6A, 16, 13, 1, -1, 1'b0);

    // Reset in the middle of the sync field
    set_in(0, 1'b1, 6'h3F);
    step();
    set_in(0, 1'b0, 6'h3F);
    repeat (300) step();
    check("busy_pre_reset", 32'({busy0, tx0}), 32'b10);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_reset", 32'({tx0, busy0, done0, pid0}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    done_seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (done0 || busy0) done_seen = 1'b1;
    end
    check("no_done_after_abort", 32'(done_seen), 32'd0);
    run_header(0, 6'h3F, 8'hBF, 16, 13, 1, -1, 1'b0);

    // Alternate timing parameters
    run_header(1, 6'h3C, 8'h3C, 4, 15, 2, -1, 1'b0);
    run_header(1, 6'h16, 8'hD6, 4, 15, 2, 20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
